alu_muldiv: RTL

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers, the successor to the single-cycle ALU's mult/mfhi/mflo/mthi paths.
- Performs signed and unsigned MULT/DIV iteratively, one bit per cycle, behind a valid/ready/done handshake.
- Sits beside the main ALU in the execute stage. The pipeline stalls on ready=0.

---
 rtl/alu_muldiv_pkg.sv | 25 ++
 rtl/alu_muldiv_if.sv | 28 ++
 rtl/alu_muldiv_step.sv | 34 +++
 rtl/alu_muldiv.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit.
// Opcodes, status bit positions and FSM state encoding.
package alu_muldiv_pkg;

    localparam logic [2:0] OP_MFHI  = 3'd0;
    localparam logic [2:0] OP_MFLO  = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_MULT  = 3'd4;
    localparam logic [2:0] OP_MULTU = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_DIVU  = 3'd7;

    localparam int ST_BUSY = 0;
    localparam int ST_DZ   = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_ZERO = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/response bundle between the execute stage and the muldiv unit.
// The master is the pipeline side, the slave is the unit.
interface alu_muldiv_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 3,
    parameter int STATUS_WIDTH = 4
);
    logic                      en_n;
    logic                      valid;
    logic [2*DATA_WIDTH-1:0]   dataIn;
    logic [CTRL_WIDTH-1:0]     ctrl;
    logic                      ready;
    logic                      done;
    logic [DATA_WIDTH-1:0]     dataOut;
    logic [DATA_WIDTH-1:0]     hi;
    logic [DATA_WIDTH-1:0]     lo;
    logic [STATUS_WIDTH-1:0]   status;

    modport master (
        output en_n, valid, dataIn, ctrl,
        input  ready, done, dataOut, hi, lo, status
    );

    modport slave (
        input  en_n, valid, dataIn, ctrl,
        output ready, done, dataOut, hi, lo, status
    );
endinterface

// File: rtl/alu_muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide step.
// Accumulator is {upper, lower}; lower holds multiplier or dividend bits.
module alu_muldiv_step #(
    parameter int W = 32
) (
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   opnd,
    input  logic           div,
    output logic [2*W-1:0] acc_nxt,
    output logic           q_bit
);
    logic [W:0]   sum;
    logic [W:0]   trial;
    logic [W-1:0] rem;

    // Compute both candidate steps and pick by mode; the quotient bit
    // is returned separately so the caller places it in the LSB.
    always_comb begin
        acc_nxt = '0;
        q_bit   = 1'b0;
        rem     = '0;
        sum     = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
        trial   = {acc[2*W-1:W], acc[W-1]} - {1'b0, opnd};
        if (div) begin
            q_bit   = ~trial[W];
            rem     = q_bit ? trial[W-1:0] : acc[2*W-2:W-1];
            acc_nxt = {rem, acc[W-2:0], 1'b0};
        end else begin
            q_bit   = acc[0];
            acc_nxt = q_bit ? {sum, acc[W-1:1]}
                            : {1'b0, acc[2*W-1:1]};
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers, one bit per cycle.
// Signed ops run on magnitudes and are sign-corrected in the FIX state.
module alu_muldiv
    import alu_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int CTRL_WIDTH   = 3,
    parameter int STATUS_WIDTH = 4,
    parameter int CNT_WIDTH    = 5
) (
    input logic         clk,
    input logic         rst_n,
    alu_muldiv_if.slave bus
);
    localparam int W = DATA_WIDTH;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    state_t                  state, state_nxt;
    logic [CNT_WIDTH-1:0]    cnt;
    logic [2*W-1:0]          acc, step_acc, prod;
    logic [W-1:0]            opnd, hi_q, lo_q, dout_q;
    logic [W-1:0]            a, b, a_mag, b_mag;
    logic [W-1:0]            q_fix, r_fix, hi_fix, lo_fix;
    logic [CTRL_WIDTH-1:0]   op;
    logic [STATUS_WIDTH-1:0] st;
    logic is_div, neg_q, neg_r, dz, ovf;
    logic st_dz, st_ovf, st_zero, done_q, step_bit, accept;
    logic op_mfhi, op_mflo, op_mthi, op_mtlo, op_md, op_sgn, op_dv;

    assign a      = bus.dataIn[2*W-1:W];
    assign b      = bus.dataIn[W-1:0];
    assign op     = bus.ctrl;
    assign accept = bus.valid & bus.ready;

    // Opcode decode and operand magnitudes for signed ops.
    always_comb begin
        op_mfhi = (op == CTRL_WIDTH'(OP_MFHI));
        op_mflo = (op == CTRL_WIDTH'(OP_MFLO));
        op_mthi = (op == CTRL_WIDTH'(OP_MTHI));
        op_mtlo = (op == CTRL_WIDTH'(OP_MTLO));
        op_sgn  = (op == CTRL_WIDTH'(OP_MULT)) | (op == CTRL_WIDTH'(OP_DIV));
        op_dv   = (op == CTRL_WIDTH'(OP_DIV)) | (op == CTRL_WIDTH'(OP_DIVU));
        op_md   = op_sgn | op_dv | (op == CTRL_WIDTH'(OP_MULTU));
        a_mag   = (op_sgn & a[W-1]) ? -a : a;
        b_mag   = (op_sgn & b[W-1]) ? -b : b;
    end

    alu_muldiv_step #(.W(W)) u_step (
        .acc     (acc),
        .opnd    (opnd),
        .div     (is_div),
        .acc_nxt (step_acc),
        .q_bit   (step_bit)
    );

    // Sign correction of the raw unsigned result.
    always_comb begin
        prod   = neg_q ? -acc : acc;
        q_fix  = neg_q ? -acc[W-1:0] : acc[W-1:0];
        r_fix  = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
        hi_fix = is_div ? r_fix : prod[2*W-1:W];
        lo_fix = is_div ? q_fix : prod[W-1:0];
    end

    // State register; en_n freezes the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (!bus.en_n) begin
            state <= state_nxt;
        end
    end

    // Next state; divide by zero skips the iterations.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && op_md) state_nxt = CALC;
            CALC:    if (dz || cnt == '0) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: accept/latch, iterate, then commit to HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            dout_q  <= '0;
            is_div  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz      <= 1'b0;
            ovf     <= 1'b0;
            st_dz   <= 1'b0;
            st_ovf  <= 1'b0;
            st_zero <= 1'b0;
            done_q  <= 1'b0;
        end else if (!bus.en_n) begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    unique case (1'b1)
                        op_mfhi: dout_q <= hi_q;
                        op_mflo: dout_q <= lo_q;
                        op_mthi: hi_q <= a;
                        op_mtlo: lo_q <= a;
                        op_md: begin
                            is_div <= op_dv;
                            neg_q  <= op_sgn & (a[W-1] ^ b[W-1]);
                            neg_r  <= op_sgn & a[W-1];
                            acc    <= op_dv ? {{W{1'b0}}, a_mag}
                                            : {{W{1'b0}}, b_mag};
                            opnd   <= op_dv ? b_mag : a_mag;
                            dz     <= op_dv & (b == '0);
                            ovf    <= op_dv & op_sgn & (a == MIN_NEG)
                                      & (b == '1);
                            cnt    <= CNT_WIDTH'(W - 1);
                            st_dz  <= 1'b0;
                            st_ovf <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                CALC: if (!dz) begin
                    acc <= step_acc
                         | {{(2*W-1){1'b0}}, is_div & step_bit};
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    done_q <= 1'b1;
                    if (dz) begin
                        st_dz   <= 1'b1;
                        st_zero <= (lo_q == '0);
                    end else begin
                        hi_q    <= hi_fix;
                        lo_q    <= lo_fix;
                        st_ovf  <= ovf;
                        st_zero <= (lo_fix == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status vector assembly.
    always_comb begin
        st          = '0;
        st[ST_BUSY] = (state != IDLE);
        st[ST_DZ]   = st_dz;
        st[ST_OVF]  = st_ovf;
        st[ST_ZERO] = st_zero;
    end

    assign bus.ready   = (state == IDLE) & ~bus.en_n;
    assign bus.done    = done_q;
    assign bus.dataOut = dout_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
    assign bus.status  = st;
endmodule
